dsc_req_alloc: RTL and testbench

DSC_REQ_ALLOC -- requirements
Module: dsc_req_alloc

---
 rtl/dsc_pkg.sv | 24 ++
 rtl/dsc_rr_arbiter.sv | 32 +++
 rtl/dsc_req_alloc.sv | 174 +++++++++++++++++
 tb/tb_dsc_req_alloc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared constants and types for the slot allocator.
package dsc_pkg;

  localparam int NUM_REQ_DEF   = 16;
  localparam int NUM_SLOTS_DEF = 4;
  localparam int MIN_HOLD_DEF  = 5;

  localparam int ID_W   = $clog2(NUM_REQ_DEF);
  localparam int SLOT_W = $clog2(NUM_SLOTS_DEF);

  // Per-requester lifecycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_OFFERED = 2'd2,
    ST_GRANTED = 2'd3
  } req_state_e;

  // Odd parity over a 32-bit word, for wrapping state in protection later.
  function automatic logic parity32(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dsc_rr_arbiter.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
module dsc_rr_arbiter #(
  parameter int N   = 16,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic           valid
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           hit;

  // Walk the ring starting at ptr and keep only the first request seen.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum   = {1'b0, ptr} + (IDW+1)'(k);
      idx   = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
      hit   = ~valid & req[idx];
      gnt[idx] = gnt[idx] | hit;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/dsc_req_alloc.sv
// Shared cache-slot allocator: per-requester FSMs, a single outstanding
// offer with valid/ready handshake, release pulses and hold-time checking.
module dsc_req_alloc
  import dsc_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int MIN_HOLD  = MIN_HOLD_DEF,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic                 alloc_valid,
  output logic [IDW-1:0]       alloc_id,
  output logic [SW-1:0]        alloc_slot,
  input  logic                 alloc_ready,
  output logic                 rel_valid,
  output logic [IDW-1:0]       rel_id,
  output logic [SW-1:0]        rel_slot,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_REQ-1:0]   hold_err
);

  localparam int CW = $clog2(MIN_HOLD + 1);

  req_state_e     st       [NUM_REQ];
  logic [SW-1:0]  slot_of  [NUM_REQ];
  logic [CW-1:0]  hold_cnt [NUM_REQ];
  logic [IDW-1:0] ptr;

  logic                 offer_live;
  logic                 accept;
  logic                 withdraw;
  logic                 can_offer;
  logic [IDW-1:0]       next_ptr;
  logic [IDW-1:0]       ptr_eff;
  logic [NUM_SLOTS-1:0] free_vec;
  logic                 free_any;
  logic [SW-1:0]        free_idx;
  logic [NUM_REQ-1:0]   pend_vec;
  logic [NUM_REQ-1:0]   rel_vec;
  logic                 rel_any;
  logic [IDW-1:0]       rel_idx;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_valid;
  logic [IDW-1:0]       sel_idx;
  logic                 do_offer;

  // Handshake decode, free-slot and release selection ahead of the arbiter.
  // A slot being accepted this cycle is not free; a slot being released is
  // still marked busy, so it can only be offered from the following edge.
  always_comb begin
    offer_live = req[alloc_id];
    accept     = alloc_valid & alloc_ready & offer_live;
    withdraw   = alloc_valid & ~offer_live;
    can_offer  = ~alloc_valid | accept | withdraw;
    next_ptr   = (alloc_id == IDW'(NUM_REQ - 1)) ? '0 : alloc_id + IDW'(1);
    ptr_eff    = accept ? next_ptr : ptr;
    free_vec   = ~slot_busy & ~(accept ? (NUM_SLOTS'(1) << alloc_slot) : '0);
    free_any   = |free_vec;
    free_idx   = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      free_idx = free_vec[s] ? SW'(s) : free_idx;
    end
    pend_vec = '0;
    rel_vec  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_vec[i] = (st[i] == ST_PENDING) & req[i];
      rel_vec[i]  = (st[i] == ST_GRANTED) & ~req[i];
    end
    rel_any = |rel_vec;
    rel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rel_idx = rel_vec[i] ? IDW'(i) : rel_idx;
    end
  end

  dsc_rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_arb (
    .req   (pend_vec),
    .ptr   (ptr_eff),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Encode the arbiter's one-hot pick and decide whether an offer is made.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_idx = sel_idx | (arb_gnt[i] ? IDW'(i) : '0);
    end
    do_offer = can_offer & free_any & arb_valid;
  end

  // All allocator state: requester FSMs, hold counters, slots and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        st[i]       <= ST_IDLE;
        slot_of[i]  <= '0;
        hold_cnt[i] <= '0;
      end
      ptr         <= '0;
      alloc_valid <= 1'b0;
      alloc_id    <= '0;
      alloc_slot  <= '0;
      rel_valid   <= 1'b0;
      rel_id      <= '0;
      rel_slot    <= '0;
      grant       <= '0;
      slot_busy   <= '0;
      hold_err    <= '0;
    end else begin
      rel_valid <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          if (hold_cnt[i] < CW'(MIN_HOLD)) hold_cnt[i] <= hold_cnt[i] + CW'(1);
        end else begin
          if ((hold_cnt[i] != '0) && (hold_cnt[i] < CW'(MIN_HOLD))) hold_err[i] <= 1'b1;
          hold_cnt[i] <= '0;
        end
        case (st[i])
          ST_IDLE: begin
            if (req[i]) st[i] <= ST_PENDING;
          end
          ST_PENDING: begin
            if (!req[i]) st[i] <= ST_IDLE;
            else if (do_offer && (sel_idx == IDW'(i))) st[i] <= ST_OFFERED;
          end
          ST_OFFERED: begin
            if (!req[i]) begin
              st[i] <= ST_IDLE;
            end else if (accept && (alloc_id == IDW'(i))) begin
              st[i]      <= ST_GRANTED;
              slot_of[i] <= alloc_slot;
              grant[i]   <= 1'b1;
            end
          end
          ST_GRANTED: begin
            if (rel_any && (rel_idx == IDW'(i))) begin
              st[i]    <= ST_IDLE;
              grant[i] <= 1'b0;
            end
          end
          default: st[i] <= ST_IDLE;
        endcase
      end
      // One release reported per cycle; further drops wait their turn.
      if (rel_any) begin
        slot_busy[slot_of[rel_idx]] <= 1'b0;
        rel_valid <= 1'b1;
        rel_id    <= rel_idx;
        rel_slot  <= slot_of[rel_idx];
      end
      if (accept) begin
        slot_busy[alloc_slot] <= 1'b1;
        ptr <= next_ptr;
      end
      if (do_offer) begin
        alloc_valid <= 1'b1;
        alloc_id    <= sel_idx;
        alloc_slot  <= free_idx;
      end else if (accept || withdraw) begin
        alloc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsc_req_alloc.sv
// Directed bench for dsc_req_alloc with hand-computed expectations.
module tb_dsc_req_alloc;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        alloc_valid;
  logic [3:0]  alloc_id;
  logic [1:0]  alloc_slot;
  logic        alloc_ready;
  logic        rel_valid;
  logic [3:0]  rel_id;
  logic [1:0]  rel_slot;
  logic [15:0] grant;
  logic [3:0]  slot_busy;
  logic [15:0] hold_err;

  int checks   = 0;
  int failures = 0;

  dsc_req_alloc dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .alloc_valid (alloc_valid),
    .alloc_id    (alloc_id),
    .alloc_slot  (alloc_slot),
    .alloc_ready (alloc_ready),
    .rel_valid   (rel_valid),
    .rel_id      (rel_id),
    .rel_slot    (rel_slot),
    .grant       (grant),
    .slot_busy   (slot_busy),
    .hold_err    (hold_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 16'h0000;
    alloc_ready = 1'b0;
    tick();
    tick();
    chk("rst_alloc_valid", {31'd0, alloc_valid}, 32'd0);
    chk("rst_grant",       {16'd0, grant},       32'd0);
    chk("rst_slot_busy",   {28'd0, slot_busy},   32'd0);
    chk("rst_hold_err",    {16'd0, hold_err},    32'd0);
    chk("rst_rel_valid",   {31'd0, rel_valid},   32'd0);
    rst = 1'b0;

    // Single requester 3, held 6 cycles, ready high.
    alloc_ready = 1'b1;
    req = 16'h0008;
    tick();
    chk("r3_no_offer_e1", {31'd0, alloc_valid}, 32'd0);
    tick();
    chk("r3_offer_valid", {31'd0, alloc_valid}, 32'd1);
    chk("r3_offer_id",    {28'd0, alloc_id},    32'd3);
    chk("r3_offer_slot",  {30'd0, alloc_slot},  32'd0);
    tick();
    chk("r3_grant",       {16'd0, grant},       32'h0008);
    chk("r3_slot_busy",   {28'd0, slot_busy},   32'h1);
    chk("r3_valid_drop",  {31'd0, alloc_valid}, 32'd0);
    tick();
    tick();
    tick();
    req = 16'h0000;
    tick();
    chk("r3_rel_valid",   {31'd0, rel_valid},   32'd1);
    chk("r3_rel_id",      {28'd0, rel_id},      32'd3);
    chk("r3_rel_slot",    {30'd0, rel_slot},    32'd0);
    chk("r3_grant_clr",   {16'd0, grant},       32'd0);
    chk("r3_busy_clr",    {28'd0, slot_busy},   32'd0);
    tick();
    chk("r3_rel_pulse",   {31'd0, rel_valid},   32'd0);
    chk("r3_no_hold_err", {16'd0, hold_err},    32'd0);

    // Five simultaneous requesters, four slots.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 16'h9221;
    tick();
    tick();
    chk("m_off0_id",   {28'd0, alloc_id},   32'd0);
    chk("m_off0_slot", {30'd0, alloc_slot}, 32'd0);
    tick();
    chk("m_off1_id",   {28'd0, alloc_id},   32'd5);
    chk("m_off1_slot", {30'd0, alloc_slot}, 32'd1);
    tick();
    chk("m_off2_id",   {28'd0, alloc_id},   32'd9);
    chk("m_off2_slot", {30'd0, alloc_slot}, 32'd2);
    tick();
    chk("m_off3_id",   {28'd0, alloc_id},   32'd12);
    chk("m_off3_slot", {30'd0, alloc_slot}, 32'd3);
    tick();
    chk("m_full_busy",  {28'd0, slot_busy},   32'hf);
    chk("m_full_grant", {16'd0, grant},       32'h1221);
    chk("m_full_novld", {31'd0, alloc_valid}, 32'd0);
    tick();
    tick();
    tick();
    chk("m_wait_novld", {31'd0, alloc_valid}, 32'd0);
    req = 16'h9220;
    tick();
    chk("m_rel0_valid", {31'd0, rel_valid},   32'd1);
    chk("m_rel0_slot",  {30'd0, rel_slot},    32'd0);
    chk("m_rel0_nooff", {31'd0, alloc_valid}, 32'd0);
    tick();
    chk("m_off15_valid", {31'd0, alloc_valid}, 32'd1);
    chk("m_off15_id",    {28'd0, alloc_id},    32'd15);
    chk("m_off15_slot",  {30'd0, alloc_slot},  32'd0);
    tick();
    chk("m_grant15",     {16'd0, grant},       32'h9220);

    // Reset with four slots granted; held lines re-offered from pointer 0.
    rst = 1'b1;
    tick();
    chk("rr_busy",   {28'd0, slot_busy},   32'd0);
    chk("rr_grant",  {16'd0, grant},       32'd0);
    chk("rr_rel",    {31'd0, rel_valid},   32'd0);
    chk("rr_valid",  {31'd0, alloc_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rr_e1_rel",  {31'd0, rel_valid},   32'd0);
    chk("rr_e1_vld",  {31'd0, alloc_valid}, 32'd0);
    tick();
    chk("rr_e2_vld",  {31'd0, alloc_valid}, 32'd1);
    chk("rr_e2_id",   {28'd0, alloc_id},    32'd5);
    chk("rr_e2_slot", {30'd0, alloc_slot},  32'd0);

    // Pointer at 6 with requesters 2 and 8 pending.
    rst = 1'b1;
    req = 16'h0000;
    tick();
    rst = 1'b0;
    req = 16'h0020;
    tick();
    tick();
    tick();
    chk("p6_grant5", {16'd0, grant}, 32'h0020);
    req = 16'h0124;
    tick();
    tick();
    chk("p6_first_id",    {28'd0, alloc_id},   32'd8);
    chk("p6_first_slot",  {30'd0, alloc_slot}, 32'd1);
    tick();
    chk("p6_second_vld",  {31'd0, alloc_valid}, 32'd1);
    chk("p6_second_id",   {28'd0, alloc_id},    32'd2);
    chk("p6_second_slot", {30'd0, alloc_slot},  32'd2);

    // Backpressure: ready low for 4 cycles, accepted on the 5th.
    rst = 1'b1;
    req = 16'h0000;
    tick();
    rst = 1'b0;
    alloc_ready = 1'b0;
    req = 16'h0002;
    tick();
    tick();
    chk("bp_offer_vld", {31'd0, alloc_valid}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("bp_hold_vld",  {31'd0, alloc_valid}, 32'd1);
      chk("bp_hold_id",   {28'd0, alloc_id},    32'd1);
      chk("bp_hold_slot", {30'd0, alloc_slot},  32'd0);
      chk("bp_no_grant",  {16'd0, grant},       32'd0);
    end
    alloc_ready = 1'b1;
    tick();
    chk("bp_accept_grant", {16'd0, grant},       32'h0002);
    chk("bp_accept_drop",  {31'd0, alloc_valid}, 32'd0);

    // Short request on 7 while its offer is pending: withdrawn, hold error.
    alloc_ready = 1'b0;
    req = 16'h0082;
    tick();
    tick();
    chk("he_offer_id",   {28'd0, alloc_id},   32'd7);
    chk("he_offer_slot", {30'd0, alloc_slot}, 32'd1);
    tick();
    req = 16'h0002;
    alloc_ready = 1'b1;
    tick();
    chk("he_withdrawn", {31'd0, alloc_valid}, 32'd0);
    chk("he_err",       {16'd0, hold_err},    32'h0080);
    chk("he_no_grant",  {16'd0, grant},       32'h0002);
    tick();
    tick();
    chk("he_sticky",    {16'd0, hold_err},    32'h0080);
    chk("he_busy",      {28'd0, slot_busy},   32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
